// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared UART definitions: FSM states, parity mode codes, parity helper.
package uart_tx_fifo_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // XOR of the low nbits of data; inverted for odd parity.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input int unsigned nbits,
                                      input int unsigned mode);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    case (mode)
      PAR_ODD:  return ~p;
      PAR_EVEN: return p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [7:0]                      wr_data,
  output logic                            full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt,
  output logic                            overflow,
  input  logic                            ovf_clr,
  output logic                            busy,
  output logic                            tx
);

  localparam int unsigned   BAUD_DIV   = SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned   BW         = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    DATA_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY_MODE != PAR_NONE);

  tx_state_t            state, state_nxt;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [2:0]           bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par, par_nxt;
  logic                 tx_nxt;
  logic                 pop;
  logic                 empty;
  logic                 baud_end;
  logic [DATA_BITS-1:0] head;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data[DATA_BITS-1:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign busy = (state != ST_IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      par      <= par_nxt;
      tx       <= tx_nxt;
    end
  end

  // Parity is latched at pop time because the shift register is consumed during DATA.
  always_comb begin
    baud_end  = (baud_cnt == BAUD_LAST);
    state_nxt = state;
    baud_nxt  = baud_end ? '0 : baud_cnt + 1'b1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    par_nxt   = par;
    tx_nxt    = tx;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          par_nxt   = parity_bit(8'(head), DATA_BITS, PARITY_MODE);
          tx_nxt    = 1'b0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          tx_nxt    = shift[0];
          shift_nxt = shift >> 1;
          bit_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
            if (HAS_PARITY) begin
              tx_nxt    = par;
              state_nxt = ST_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = ST_STOP;
            end
          end else begin
            tx_nxt    = shift[0];
            shift_nxt = shift >> 1;
            bit_nxt   = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          tx_nxt    = 1'b1;
          bit_nxt   = '0;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt = '0;
            if (!empty) begin
              pop       = 1'b1;
              shift_nxt = head;
              par_nxt   = parity_bit(8'(head), DATA_BITS, PARITY_MODE);
              tx_nxt    = 1'b0;
              state_nxt = ST_START;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overflow <= 1'b0;
    else if (ovf_clr)          overflow <= 1'b0;
    else if (wr_en && full)    overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors decode tx.
module tb_uart_tx_fifo_ctrl;

  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          we0 = 1'b0, we1 = 1'b0, we2 = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          full0, full1, full2;
  logic          ovf0, ovf1, ovf2;
  logic          busy0, busy1, busy2;
  logic          tx0, tx1, tx2;
  logic [CW-1:0] cnt0, cnt1, cnt2;
  logic [2:0]    txs;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  len;
    logic        b2b;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  uart_tx_fifo_ctrl #(
    .SYS_CLK_FREQ (400), .BAUD_RATE (100), .DATA_BITS (8),
    .PARITY_MODE (0), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) u_none (
    .clk (clk), .rst_n (rst_n), .wr_en (we0), .wr_data (wr_data),
    .full (full0), .fifo_cnt (cnt0), .overflow (ovf0), .ovf_clr (ovf_clr),
    .busy (busy0), .tx (tx0)
  );

  uart_tx_fifo_ctrl #(
    .SYS_CLK_FREQ (400), .BAUD_RATE (100), .DATA_BITS (8),
    .PARITY_MODE (2), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) u_even (
    .clk (clk), .rst_n (rst_n), .wr_en (we1), .wr_data (wr_data),
    .full (full1), .fifo_cnt (cnt1), .overflow (ovf1), .ovf_clr (ovf_clr),
    .busy (busy1), .tx (tx1)
  );

  uart_tx_fifo_ctrl #(
    .SYS_CLK_FREQ (400), .BAUD_RATE (100), .DATA_BITS (8),
    .PARITY_MODE (1), .STOP_BITS (1), .FIFO_DEPTH (16)
  ) u_odd (
    .clk (clk), .rst_n (rst_n), .wr_en (we2), .wr_data (wr_data),
    .full (full2), .fifo_cnt (cnt2), .overflow (ovf2), .ovf_clr (ovf_clr),
    .busy (busy2), .tx (tx2)
  );

  assign txs = {tx2, tx1, tx0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line bits in transmit order: start, d0..d7, optional parity, stop.
  function automatic frame_t make_frame(input logic [7:0] d, input bit use_par,
                                        input logic pbit, input bit b2b);
    frame_t f;
    f.bits = '0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    if (use_par) begin
      f.bits[9]  = pbit;
      f.bits[10] = 1'b1;
      f.len      = 5'd11;
    end else begin
      f.bits[9]  = 1'b1;
      f.len      = 5'd10;
    end
    f.b2b = b2b;
    return f;
  endfunction

  // len == 0 marks a frame that is expected to be cut short by reset.
  function automatic frame_t abort_frame();
    frame_t f;
    f = '0;
    return f;
  endfunction

  task automatic expect_frame(input int unsigned id, input frame_t f);
    case (id)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  function automatic bit pop_exp(input int unsigned id, output frame_t f);
    f = '0;
    case (id)
      0: if (q0.size() > 0) begin f = q0.pop_front(); return 1'b1; end
      1: if (q1.size() > 0) begin f = q1.pop_front(); return 1'b1; end
      default: if (q2.size() > 0) begin f = q2.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  task automatic monitor(input int unsigned id);
    frame_t      f;
    logic [15:0] obs;
    bit          ok;
    bit          have;
    int unsigned last_end;
    int unsigned n;
    logic        t;
    last_end = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txs[id] === 1'b0) begin
        have = pop_exp(id, f);
        chk($sformatf("m%0d_frame_expected", id), 32'(have), 32'd1);
        if (have && f.len == 5'd0) begin
          n = 0;
          while (rst_n === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
          end
          chk($sformatf("m%0d_abort_rst", id), 32'(rst_n), 32'd0);
          chk($sformatf("m%0d_abort_tx", id), 32'(txs[id]), 32'd1);
        end else if (have) begin
          if (f.b2b) chk($sformatf("m%0d_b2b_gap", id), cyc - last_end, 32'd1);
          ok  = 1'b1;
          obs = '0;
          for (int k = 0; k < int'(f.len) * 4; k++) begin
            if (k > 0) @(negedge clk);
            t = txs[id];
            if (rst_n !== 1'b1 || t !== f.bits[k/4]) ok = 1'b0;
            if (k % 4 == 2) obs[k/4] = t;
          end
          last_end = cyc;
          chk($sformatf("m%0d_frame_bits", id), 32'(obs), 32'(f.bits));
          chk($sformatf("m%0d_frame_timing", id), 32'(ok), 32'd1);
        end
      end
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while ((busy0 || busy1 || busy2) && n < 3000) begin
      tick(1);
      n++;
    end
    tick(2);
    chk({name, "_drained"}, 32'(busy0 | busy1 | busy2), 32'd0);
    chk({name, "_q0_empty"}, q0.size(), 32'd0);
  endtask

  // Counts negedges from the current one until busy of the selected DUT drops.
  task automatic busy_len(input int unsigned id, output int unsigned n);
    logic b;
    n = 0;
    b = 1'b1;
    while (b && n < 200) begin
      tick(1);
      n++;
      case (id)
        0:       b = busy0;
        1:       b = busy1;
        default: b = busy2;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned n1, n2;
    bit idle_ok;

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    // Reset state
    tick(2);
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_full", 32'(full0), 32'd0);
    chk("rst_cnt", 32'(cnt0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_tx_par", 32'({tx2, tx1}), 32'd3);
    #2 rst_n = 1'b1;
    tick(2);

    // 1: single byte, no parity
    wr_data = 8'hA5; we0 = 1'b1;
    expect_frame(0, make_frame(8'hA5, 1'b0, 1'b0, 1'b0));
    tick(1);
    we0 = 1'b0;
    chk("t1_tx_before", 32'(tx0), 32'd1);
    chk("t1_cnt_after_wr", 32'(cnt0), 32'd1);
    chk("t1_busy", 32'(busy0), 32'd1);
    tick(1);
    chk("t1_tx_start", 32'(tx0), 32'd0);
    chk("t1_cnt_popped", 32'(cnt0), 32'd0);
    busy_len(0, n1);
    chk("t1_busy_len", n1, 32'd40);
    drain("t1");

    // 2: even and odd parity, 8'h07
    wr_data = 8'h07; we1 = 1'b1; we2 = 1'b1;
    expect_frame(1, make_frame(8'h07, 1'b1, 1'b1, 1'b0));
    expect_frame(2, make_frame(8'h07, 1'b1, 1'b0, 1'b0));
    tick(1);
    we1 = 1'b0; we2 = 1'b0;
    tick(1);
    chk("t2_start", 32'({tx2, tx1}), 32'd0);
    fork
      busy_len(1, n1);
      busy_len(2, n2);
    join
    chk("t2_even_len", n1, 32'd44);
    chk("t2_odd_len", n2, 32'd44);
    drain("t2");
    chk("t2_q1_empty", q1.size(), 32'd0);
    chk("t2_q2_empty", q2.size(), 32'd0);

    // 3: three consecutive writes, back-to-back frames
    we0 = 1'b1; wr_data = 8'h3C;
    expect_frame(0, make_frame(8'h3C, 1'b0, 1'b0, 1'b0));
    tick(1);
    chk("t3_cnt_k", 32'(cnt0), 32'd1);
    wr_data = 8'hC3;
    expect_frame(0, make_frame(8'hC3, 1'b0, 1'b0, 1'b1));
    tick(1);
    chk("t3_cnt_k1", 32'(cnt0), 32'd1);
    wr_data = 8'h5A;
    expect_frame(0, make_frame(8'h5A, 1'b0, 1'b0, 1'b1));
    tick(1);
    we0 = 1'b0;
    chk("t3_cnt_k2", 32'(cnt0), 32'd2);
    tick(38);
    chk("t3_cnt_k40", 32'(cnt0), 32'd2);
    tick(1);
    chk("t3_cnt_k41", 32'(cnt0), 32'd1);
    tick(40);
    chk("t3_cnt_k81", 32'(cnt0), 32'd0);
    drain("t3");

    // 4: fill while busy, overflow, clear priority
    for (int i = 0; i < 17; i++) begin
      we0 = 1'b1;
      wr_data = 8'(i * 37 + 1);
      expect_frame(0, make_frame(8'(i * 37 + 1), 1'b0, 1'b0, (i > 0)));
      tick(1);
    end
    chk("t4_full", 32'(full0), 32'd1);
    chk("t4_cnt_full", 32'(cnt0), 32'd16);
    chk("t4_ovf_before", 32'(ovf0), 32'd0);
    wr_data = 8'hEE;
    tick(1);
    we0 = 1'b0;
    chk("t4_ovf_set", 32'(ovf0), 32'd1);
    chk("t4_cnt_drop", 32'(cnt0), 32'd16);
    we0 = 1'b1; wr_data = 8'hEF; ovf_clr = 1'b1;
    tick(1);
    we0 = 1'b0; ovf_clr = 1'b0;
    chk("t4_ovf_clr_wins", 32'(ovf0), 32'd0);
    chk("t4_cnt_still", 32'(cnt0), 32'd16);
    drain("t4");

    // 5: reset mid-DATA
    we0 = 1'b1; wr_data = 8'hFF;
    expect_frame(0, abort_frame());
    tick(1);
    we0 = 1'b0;
    tick(2);
    we0 = 1'b1; wr_data = 8'h81;
    tick(1);
    we0 = 1'b0;
    tick(8);
    chk("t5_cnt_pre", 32'(cnt0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_tx_rst", 32'(tx0), 32'd1);
    chk("t5_cnt_rst", 32'(cnt0), 32'd0);
    chk("t5_busy_rst", 32'(busy0), 32'd0);
    tick(3);
    #2 rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) idle_ok = 1'b0;
    end
    chk("t5_idle_after", 32'(idle_ok), 32'd1);
    chk("t5_q0_empty", q0.size(), 32'd0);

    // 6: push and pop in the same cycle with one entry queued
    we0 = 1'b1; wr_data = 8'h96;
    expect_frame(0, make_frame(8'h96, 1'b0, 1'b0, 1'b0));
    tick(1);
    we0 = 1'b0;
    tick(2);
    we0 = 1'b1; wr_data = 8'h4D;
    expect_frame(0, make_frame(8'h4D, 1'b0, 1'b0, 1'b1));
    tick(1);
    we0 = 1'b0;
    chk("t6_cnt_one", 32'(cnt0), 32'd1);
    tick(37);
    we0 = 1'b1; wr_data = 8'hE1;
    expect_frame(0, make_frame(8'hE1, 1'b0, 1'b0, 1'b1));
    chk("t6_cnt_pre", 32'(cnt0), 32'd1);
    tick(1);
    we0 = 1'b0;
    chk("t6_cnt_pushpop", 32'(cnt0), 32'd1);
    drain("t6");
    chk("end_q1_empty", q1.size(), 32'd0);
    chk("end_q2_empty", q2.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
